// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared types and helpers for the sequential restoring divider:
//            controller state encoding and iteration-counter width.
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

  // Width of the controller state register
  localparam int STATE_W = 3;

  // Controller states; FIXUP is only visited in the signed build
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    CALC  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Counter width able to hold 0..width
  function automatic int calc_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/restoring_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : restoring_div_ctrl
// Purpose  : Controller for the restoring divider. Owns the state machine,
//            the iteration counter and the valid/ready handshakes, and drives
//            one-cycle strobes that steer the datapath in the top level.
//            Optional signed support: RESTORING_DIVIDER_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module restoring_div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic out_ready,
  input  logic m_zero,
  input  logic q_zero,
`ifdef RESTORING_DIVIDER_SIGNED_EN
  input  logic ovf_case,
  output logic chk_ovf,
  output logic fixup,
`endif
  output logic in_ready,
  output logic out_valid,
  output logic busy,
  output logic load,
  output logic chk_dbz,
  output logic chk_zero,
  output logic calc_start,
  output logic step,
  output logic latch
);

  localparam int CNT_W = calc_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

  // Next-state, counter and datapath strobe decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    chk_dbz    = 1'b0;
    chk_zero   = 1'b0;
    calc_start = 1'b0;
    step       = 1'b0;
    latch      = 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
    chk_ovf    = 1'b0;
    fixup      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          load    = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // Zero divisor outranks every other early exit
        if (m_zero) begin
          chk_dbz = 1'b1;
          state_d = DONE;
`ifdef RESTORING_DIVIDER_SIGNED_EN
        end else if (ovf_case) begin
          chk_ovf = 1'b1;
          state_d = DONE;
`endif
        end else if (q_zero) begin
          chk_zero = 1'b1;
          state_d  = DONE;
        end else begin
          calc_start = 1'b1;
          cnt_d      = '0;
          state_d    = CALC;
        end
      end
      CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          latch = 1'b1;
`ifdef RESTORING_DIVIDER_SIGNED_EN
          state_d = FIXUP;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef RESTORING_DIVIDER_SIGNED_EN
      FIXUP: begin
        fixup   = 1'b1;
        state_d = DONE;
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State, counter and registered handshake outputs; reset abandons any op
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/restoring_divider_seq.sv
`default_nettype none
// ============================================================================
// Module   : restoring_divider_seq
// Purpose  : Sequential restoring divider, one quotient bit per clock, with
//            valid/ready handshakes and early exit on zero operands. Holds the
//            A/Q/M registers, the trial subtractor and the result registers.
//            Optional signed support: RESTORING_DIVIDER_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module restoring_divider_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
`ifdef RESTORING_DIVIDER_SIGNED_EN
  input  logic             is_signed,
  output logic             overflow,
`endif
  output logic             busy
);

  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic load, chk_dbz, chk_zero, calc_start, step, latch;

  // The shifted partial remainder is formed one bit wider than A. A's top bit
  // never sets (the partial remainder stays below M), so the extra bit only
  // carries the borrow and matches D[WIDTH] of the WIDTH+1-bit difference.
  logic [WIDTH+1:0] w_s;
  logic [WIDTH+1:0] w_diff;
  logic             w_neg;
  logic [WIDTH:0]   w_a_next;
  logic [WIDTH-1:0] w_q_next;

  assign w_s      = {a_q, q_q[WIDTH-1]};
  assign w_diff   = w_s - {2'b00, m_q};
  assign w_neg    = w_diff[WIDTH+1];
  assign w_a_next = w_neg ? w_s[WIDTH:0] : w_diff[WIDTH:0];
  assign w_q_next = {q_q[WIDTH-2:0], ~w_neg};

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

`ifdef RESTORING_DIVIDER_SIGNED_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic sgn_q, sgn_d;
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;
  logic ovf_q, ovf_d;
  logic chk_ovf, fixup;
  logic w_ovf_case;

  assign w_ovf_case = sgn_q && (q_q == MOST_NEG) && (m_q == '1);
  assign overflow   = ovf_q;
`endif

  restoring_div_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .m_zero     (m_q == '0),
    .q_zero     (q_q == '0),
`ifdef RESTORING_DIVIDER_SIGNED_EN
    .ovf_case   (w_ovf_case),
    .chk_ovf    (chk_ovf),
    .fixup      (fixup),
`endif
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .busy       (busy),
    .load       (load),
    .chk_dbz    (chk_dbz),
    .chk_zero   (chk_zero),
    .calc_start (calc_start),
    .step       (step),
    .latch      (latch)
  );

  // Datapath next-state: operand load, early-exit results, iteration, latch
  always_comb begin
    a_d         = a_q;
    q_d         = q_q;
    m_d         = m_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef RESTORING_DIVIDER_SIGNED_EN
    sgn_d       = sgn_q;
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
    ovf_d       = ovf_q;
`endif
    if (load) begin
      q_d = dividend;
      m_d = divisor;
      a_d = '0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      sgn_d = is_signed;
`endif
    end
    // Q still holds the raw dividend here, so it is the remainder as-is
    if (chk_dbz) begin
      quotient_d  = '1;
      remainder_d = q_q;
      dbz_d       = 1'b1;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      ovf_d       = 1'b0;
`endif
    end
    if (chk_zero) begin
      quotient_d  = '0;
      remainder_d = '0;
      dbz_d       = 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      ovf_d       = 1'b0;
`endif
    end
    if (calc_start) begin
      dbz_d = 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      ovf_d      = 1'b0;
      q_d        = (sgn_q && q_q[WIDTH-1]) ? -q_q : q_q;
      m_d        = (sgn_q && m_q[WIDTH-1]) ? -m_q : m_q;
      neg_quot_d = sgn_q && (q_q[WIDTH-1] ^ m_q[WIDTH-1]);
      neg_rem_d  = sgn_q && q_q[WIDTH-1];
`endif
    end
    if (step) begin
      a_d = w_a_next;
      q_d = w_q_next;
    end
    if (latch) begin
      quotient_d  = w_q_next;
      remainder_d = w_a_next[WIDTH-1:0];
    end
`ifdef RESTORING_DIVIDER_SIGNED_EN
    if (chk_ovf) begin
      quotient_d  = MOST_NEG;
      remainder_d = '0;
      dbz_d       = 1'b0;
      ovf_d       = 1'b1;
    end
    // Truncating division: quotient sign from both operands, remainder
    // follows the dividend
    if (fixup) begin
      quotient_d  = neg_quot_q ? -quotient_q : quotient_q;
      remainder_d = neg_rem_q ? -remainder_q : remainder_q;
    end
`endif
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      sgn_q       <= 1'b0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      sgn_q       <= sgn_d;
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_restoring_divider_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_restoring_divider_seq
// Purpose  : Directed self-checking bench for restoring_divider_seq (8-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_restoring_divider_seq;

`ifdef RESTORING_DIVIDER_SIGNED_EN
  localparam int NORM_LAT = 10;
`else
  localparam int NORM_LAT = 9;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
  logic       busy;
`ifdef RESTORING_DIVIDER_SIGNED_EN
  logic       is_signed = 1'b0;
  logic       overflow;
`endif

  int total = 0;
  int bad = 0;

  restoring_divider_seq #(
    .WIDTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
`ifdef RESTORING_DIVIDER_SIGNED_EN
    .is_signed   (is_signed),
    .overflow    (overflow),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait (bounded) for out_valid, check latency and results
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic edbz, input logic eovf, input int elat);
    int lat;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
`ifdef RESTORING_DIVIDER_SIGNED_EN
    is_signed = sgn;
`else
    if (sgn) $display("note: signed op requested in unsigned build");
`endif
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, elat);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, edbz);
`ifdef RESTORING_DIVIDER_SIGNED_EN
    chk("overflow", overflow, eovf);
`else
    if (eovf) $display("note: overflow expectation ignored in unsigned build");
`endif
    chk("in_ready_done", in_ready, 0);
    chk("busy_done", busy, 1);
  endtask

  // Consume the pending result and confirm return to IDLE
  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_busy", busy, 0);

    do_op(8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, 1'b0, NORM_LAT);   take();
    do_op(8'd5, 8'd0, 1'b0, 8'hFF, 8'd5, 1'b1, 1'b0, 1);            take();
    do_op(8'd0, 8'd9, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1);             take();
    do_op(8'd0, 8'd0, 1'b0, 8'hFF, 8'd0, 1'b1, 1'b0, 1);            take();
    do_op(8'd255, 8'd1, 1'b0, 8'd255, 8'd0, 1'b0, 1'b0, NORM_LAT);  take();
    do_op(8'd1, 8'd255, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0, NORM_LAT);    take();
    do_op(8'd255, 8'd255, 1'b0, 8'd1, 8'd0, 1'b0, 1'b0, NORM_LAT);  take();
    do_op(8'd254, 8'd16, 1'b0, 8'd15, 8'd14, 1'b0, 1'b0, NORM_LAT); take();

    // Result held while the consumer stalls
    do_op(8'd100, 8'd3, 1'b0, 8'd33, 8'd1, 1'b0, 1'b0, NORM_LAT);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_quotient", quotient, 33);
      chk("hold_remainder", remainder, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    take();

    // Reset during the 4th CALC cycle of 200/7
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    chk("mid_out_valid", out_valid, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_quotient", quotient, 0);
    chk("mid_rst_remainder", remainder, 0);
    chk("mid_rst_dbz", div_by_zero, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_stays_idle", out_valid, 0);
    do_op(8'd9, 8'd2, 1'b0, 8'd4, 8'd1, 1'b0, 1'b0, NORM_LAT); take();

`ifdef RESTORING_DIVIDER_SIGNED_EN
    do_op(8'hF9, 8'd2, 1'b1, 8'hFD, 8'hFF, 1'b0, 1'b0, NORM_LAT);   take();
    do_op(8'd7, 8'hFE, 1'b1, 8'hFD, 8'd1, 1'b0, 1'b0, NORM_LAT);    take();
    do_op(8'h80, 8'hFF, 1'b1, 8'h80, 8'd0, 1'b0, 1'b1, 1);          take();
    do_op(8'hF9, 8'd0, 1'b1, 8'hFF, 8'hF9, 1'b1, 1'b0, 1);          take();
    do_op(8'hF9, 8'd2, 1'b0, 8'd124, 8'd1, 1'b0, 1'b0, NORM_LAT);   take();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
